pipeline_hazard_controller: RTL and testbench

//  Central hazard sequencer for the 5-stage pipeline. Resolves MEM-stage branches via
//  one Branch_Detection_Unit instance. Drives PC source, per-stage write/flush controls,

---
 rtl/pipeline_hazard_controller_pkg.sv | 25 ++
 rtl/pipeline_hazard_controller_bdu.sv | 21 ++
 rtl/pipeline_hazard_controller.sv | 153 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// rtl/pipeline_hazard_controller_pkg.sv - shared branch-type and hazard-state encodings
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        BT_NONE = 2'b00,
        BT_BEQ  = 2'b01,
        BT_BNE  = 2'b10,
        BT_BLTZ = 2'b11
    } branch_type_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_DRAIN = 2'b10,
        ST_HALT  = 2'b11
    } hazard_state_e;

    // One counter serves both stall and drain, so size it for the longer of the two.
    function automatic int cnt_width(input int stall_cycles, input int drain_cycles);
        int m;
        m = (stall_cycles > drain_cycles) ? stall_cycles : drain_cycles;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_bdu.sv
// rtl/pipeline_hazard_controller_bdu.sv - branch resolution from MEM-stage ALU flags
module Branch_Detection_Unit
    import pipeline_hazard_controller_pkg::*;
(
    input  logic [1:0] BranchType,
    input  logic       Zero,
    input  logic       Sign,
    output logic       Branch
);

    always_comb begin
        Branch = 1'b0;
        case (BranchType)
            BT_BEQ:  Branch = Zero;
            BT_BNE:  Branch = ~Zero;
            BT_BLTZ: Branch = Sign;
            default: Branch = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - pipeline hazard sequencer: branch flush, load-use stall, halt drain
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int STALL_CYCLES = 1,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_UsesRt,
    input  logic             ID_Halt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rt,
    input  logic [1:0]       MEM_BranchType,
    input  logic             MEM_Zero,
    input  logic             MEM_Sign,
    output logic             PCSrc,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic             Halted,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] TakenCount
);

    localparam int CW = cnt_width(STALL_CYCLES, DRAIN_CYCLES);

    hazard_state_e    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] branch_count_q, taken_count_q;
    logic             branch;
    logic             load_use;

    Branch_Detection_Unit u_bdu (
        .BranchType (MEM_BranchType),
        .Zero       (MEM_Zero),
        .Sign       (MEM_Sign),
        .Branch     (branch)
    );

    assign load_use = EX_MemRead & (EX_rt != 5'd0) &
                      ((EX_rt == ID_rs) | (ID_UsesRt & (EX_rt == ID_rt)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        PCSrc       = 1'b0;
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        EXMEM_Flush = 1'b0;

        if (state_q == ST_HALT) begin
            PC_Write   = 1'b0;
            IFID_Write = 1'b0;
        end else if (branch) begin
            // Everything younger than MEM is wrong-path, including a pending HALT.
            PCSrc       = 1'b1;
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
            state_d     = ST_RUN;
            cnt_d       = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (load_use) begin
                        PC_Write   = 1'b0;
                        IFID_Write = 1'b0;
                        IDEX_Flush = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            state_d = ST_STALL;
                            cnt_d   = CW'(STALL_CYCLES - 1);
                        end
                    end else if (ID_Halt) begin
                        PC_Write   = 1'b0;
                        IFID_Write = 1'b0;
                        state_d    = ST_DRAIN;
                        cnt_d      = CW'(DRAIN_CYCLES);
                    end
                end
                ST_STALL: begin
                    PC_Write   = 1'b0;
                    IFID_Write = 1'b0;
                    IDEX_Flush = 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    PC_Write   = 1'b0;
                    IFID_Write = 1'b0;
                    IFID_Flush = 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_HALT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        // Hold the pipeline fully quiet while reset is asserted.
        if (Reset) begin
            PCSrc       = 1'b0;
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IFID_Flush  = 1'b0;
            IDEX_Flush  = 1'b0;
            EXMEM_Flush = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            branch_count_q <= '0;
            taken_count_q  <= '0;
        end else if (MEM_BranchType != BT_NONE) begin
            if (branch_count_q != '1) begin
                branch_count_q <= branch_count_q + 1'b1;
            end
            if (branch && (taken_count_q != '1)) begin
                taken_count_q <= taken_count_q + 1'b1;
            end
        end
    end

    assign Halted      = (state_q == ST_HALT);
    assign BranchCount = branch_count_q;
    assign TakenCount  = taken_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - self-checking bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

    typedef struct packed {
        logic [1:0] bt;
        logic       zero;
        logic       sign;
        logic       memread;
        logic [4:0] ex_rt;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       uses_rt;
        logic       halt;
    } in_t;

    typedef struct {
        in_t        in;
        logic [6:0] exp;
        logic [6:0] follow;
    } vec_t;

    // {PCSrc, PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, Halted}
    localparam logic [6:0] RUNO   = 7'b0110000;
    localparam logic [6:0] BR     = 7'b1111110;
    localparam logic [6:0] STL    = 7'b0000100;
    localparam logic [6:0] HLTDEC = 7'b0000000;
    localparam logic [6:0] DRN    = 7'b0001000;
    localparam logic [6:0] HLT    = 7'b0000001;
    localparam logic [6:0] RST    = 7'b0000000;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [4:0] ID_rs, ID_rt, EX_rt;
    logic       ID_UsesRt, ID_Halt, EX_MemRead;
    logic [1:0] MEM_BranchType;
    logic       MEM_Zero, MEM_Sign;
    logic       PCSrc, PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, Halted;
    logic [3:0] BranchCount, TakenCount;

    int total = 0;
    int bad   = 0;
    logic [6:0] exp_q[$];
    vec_t vecs[14];
    int bc, tc;

    pipeline_hazard_controller #(
        .STALL_CYCLES (2),
        .DRAIN_CYCLES (3),
        .CNT_W        (4)
    ) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .ID_rs          (ID_rs),
        .ID_rt          (ID_rt),
        .ID_UsesRt      (ID_UsesRt),
        .ID_Halt        (ID_Halt),
        .EX_MemRead     (EX_MemRead),
        .EX_rt          (EX_rt),
        .MEM_BranchType (MEM_BranchType),
        .MEM_Zero       (MEM_Zero),
        .MEM_Sign       (MEM_Sign),
        .PCSrc          (PCSrc),
        .PC_Write       (PC_Write),
        .IFID_Write     (IFID_Write),
        .IFID_Flush     (IFID_Flush),
        .IDEX_Flush     (IDEX_Flush),
        .EXMEM_Flush    (EXMEM_Flush),
        .Halted         (Halted),
        .BranchCount    (BranchCount),
        .TakenCount     (TakenCount)
    );

    always #5 CLK = ~CLK;

    function automatic in_t mk(input logic [1:0] bt, input logic z, input logic s,
                               input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                               input logic [4:0] rt, input logic ur, input logic h);
        in_t v;
        v = '{bt: bt, zero: z, sign: s, memread: mr, ex_rt: ert, id_rs: rs,
              id_rt: rt, uses_rt: ur, halt: h};
        return v;
    endfunction

    task automatic apply(input in_t v);
        MEM_BranchType = v.bt;
        MEM_Zero       = v.zero;
        MEM_Sign       = v.sign;
        EX_MemRead     = v.memread;
        EX_rt          = v.ex_rt;
        ID_rs          = v.id_rs;
        ID_rt          = v.id_rt;
        ID_UsesRt      = v.uses_rt;
        ID_Halt        = v.halt;
    endtask

    task automatic check_out(input string nm);
        logic [6:0] e, act;
        total++;
        act = {PCSrc, PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, Halted};
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, got %b", nm, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                bad++;
                $display("FAIL %s: got %b expected %b (PCSrc,PCW,IFIDW,IFIDF,IDEXF,EXMEMF,Halted)",
                         nm, act, e);
            end
        end
    endtask

    task automatic check_val(input string nm, input logic [3:0] act, input logic [3:0] e);
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, e);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare at the falling edge.
    task automatic step(input in_t v, input logic [6:0] e, input string nm);
        apply(v);
        exp_q.push_back(e);
        @(negedge CLK);
        check_out(nm);
        @(posedge CLK);
        #1;
    endtask

    // Asynchronous reset pulse landing between clock edges.
    task automatic pulse_reset(input string nm);
        #2;
        Reset = 1'b1;
        #1;
        exp_q.push_back(RST);
        check_out(nm);
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        in_t idle, beq_t, halt_in, lu_in;
        idle    = mk(2'b00, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
        beq_t   = mk(2'b01, 1, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
        halt_in = mk(2'b00, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 1);
        lu_in   = mk(2'b00, 0, 0, 1, 5'd8, 5'd8, 5'd2, 0, 0);

        vecs[0]  = '{idle,                                          RUNO, RUNO};
        vecs[1]  = '{mk(2'b01, 1, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0),    BR,   RUNO};
        vecs[2]  = '{mk(2'b01, 0, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0),    RUNO, RUNO};
        vecs[3]  = '{mk(2'b10, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0),    BR,   RUNO};
        vecs[4]  = '{mk(2'b10, 1, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0),    RUNO, RUNO};
        vecs[5]  = '{mk(2'b11, 0, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0),    BR,   RUNO};
        vecs[6]  = '{mk(2'b11, 1, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0),    RUNO, RUNO};
        vecs[7]  = '{mk(2'b00, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0),    RUNO, RUNO};
        vecs[8]  = '{lu_in,                                         STL,  STL};
        vecs[9]  = '{mk(2'b00, 0, 0, 1, 5'd9, 5'd3, 5'd9, 1, 0),    STL,  STL};
        vecs[10] = '{mk(2'b00, 0, 0, 1, 5'd9, 5'd3, 5'd9, 0, 0),    RUNO, RUNO};
        vecs[11] = '{mk(2'b00, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0),    RUNO, RUNO};
        vecs[12] = '{mk(2'b00, 0, 0, 0, 5'd8, 5'd8, 5'd8, 1, 0),    RUNO, RUNO};
        vecs[13] = '{mk(2'b11, 0, 1, 1, 5'd8, 5'd8, 5'd2, 0, 0),    BR,   RUNO};

        Reset = 1'b1;
        apply(idle);
        #12;
        exp_q.push_back(RST);
        check_out("reset_outputs");
        check_val("reset_branch_count", BranchCount, 4'd0);
        check_val("reset_taken_count", TakenCount, 4'd0);
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK);
        #1;

        bc = 0;
        tc = 0;
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].in, vecs[i].exp, $sformatf("vec%0d", i));
            if (vecs[i].in.bt != 2'b00 && bc < 15) bc++;
            if (vecs[i].in.bt != 2'b00 && vecs[i].exp[6] && tc < 15) tc++;
            step(idle, vecs[i].follow, $sformatf("vec%0d_next", i));
            step(idle, RUNO, $sformatf("vec%0d_recover", i));
        end
        check_val("table_branch_count", BranchCount, 4'(bc));
        check_val("table_taken_count", TakenCount, 4'(tc));

        pulse_reset("reset_before_halt");
        step(halt_in, HLTDEC, "halt_decode");
        for (int i = 0; i < 3; i++) step(idle, DRN, $sformatf("drain%0d", i));
        step(idle, HLT, "halted");
        step(beq_t, HLT, "halt_ignores_branch");
        step(idle, HLT, "halt_holds");

        pulse_reset("reset_after_halt");
        step(halt_in, HLTDEC, "halt2_decode");
        step(idle, DRN, "halt2_drain");
        step(beq_t, BR, "drain_branch_cancels");
        for (int i = 0; i < 5; i++) step(idle, RUNO, $sformatf("cancel_run%0d", i));

        pulse_reset("reset_before_sat");
        check_val("sat_start_count", BranchCount, 4'd0);
        for (int i = 0; i < 20; i++) step(beq_t, BR, $sformatf("sat_br%0d", i));
        check_val("sat_branch_count", BranchCount, 4'hF);
        check_val("sat_taken_count", TakenCount, 4'hF);

        step(lu_in, STL, "stall_then_reset");
        apply(idle);
        pulse_reset("async_reset_in_stall");
        check_val("stall_reset_count", BranchCount, 4'd0);
        step(idle, RUNO, "after_stall_reset0");
        step(idle, RUNO, "after_stall_reset1");

        step(halt_in, HLTDEC, "halt3_decode");
        step(idle, DRN, "halt3_drain");
        pulse_reset("async_reset_in_drain");
        for (int i = 0; i < 4; i++) step(idle, RUNO, $sformatf("after_drain_reset%0d", i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
